snd_mix_dac: RTL

Parametrised sound output stage for the sound subsystem. It mixes up to 4 signed PCM channels with per-channel CPU-programmable volume and mute, saturates the result to 16 bits, and serialises each mixed sample to the external DAC. Two output formats are supported: YM3014 floating-point serial, or I2S with the mono mix duplicated on both channels. It sits between the sound generators (OPL2 core, PCM/beeper sources) and the board DAC pins, and replaces per-source DAC drivers.

---
 rtl/snd_pkg.sv | 15 +
 rtl/snd_ym_float.sv | 18 +
 rtl/snd_mix_dac.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/snd_pkg.sv
// snd_pkg: shared constants, field positions and types for the sound output stage
package snd_pkg;
    localparam int MODE_YM = 0;
    localparam int MODE_I2S = 1;
    localparam int YM_FRAME = 16;
    localparam int I2S_SLOTS = 32;
    localparam logic [4:0] VOL_UNITY = 5'd16;
    localparam int MUTE_BIT = 7;
    localparam int VOL_MSB = 4;
    localparam logic [7:0] VOL_RESET = {3'b000, VOL_UNITY};
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} serState_t;
    function automatic logic [4:0] clampVol(input logic [4:0] v);
        return (v > VOL_UNITY) ? VOL_UNITY : v;
    endfunction
endpackage

// File: rtl/snd_ym_float.sv
// snd_ym_float: combinational 16-bit linear to YM3014 floating-point frame encoder
module snd_ym_float
    import snd_pkg::*;
(
    input  logic [15:0]         sample,
    output logic [YM_FRAME-1:0] frame
);
    logic [2:0] k;
    logic [9:0] mant;
    // k = run of sign copies below the sign bit, stopping at the first differing bit
    always_comb begin
        k = 3'd6;
        for (int i = 5; i >= 0; i--)
            if (sample[14 - i] != sample[15]) k = 3'(i);
    end
    assign mant = 10'(sample >> (3'd6 - k));
    assign frame = {3'd7 - k, ~mant[9], mant[8:0], 3'b000};
endmodule

// File: rtl/snd_mix_dac.sv
// snd_mix_dac: volume-scaled mixer with saturation and YM3014 / I2S serial DAC output
module snd_mix_dac
    import snd_pkg::*;
#(
    parameter int          CHANNELS = 2,
    parameter int          MODE     = MODE_YM,
    parameter int          DIV      = 4,
    parameter logic [11:0] BASE     = 12'h38C
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iWr,
    input  logic [7:0]              iWrData,
    input  logic [19:0]             iAddr,
    input  logic                    iSampleEn,
    input  logic [16*CHANNELS-1:0]  iSamples,
    output logic                    oSd,
    output logic                    oBck,
    output logic                    oLoad,
    output logic                    oOverrun
);
    localparam logic [5:0] LAST_SLOT = (MODE == MODE_I2S) ? 6'(I2S_SLOTS) : 6'(YM_FRAME);

    logic [7:0] volReg [4];
    logic signed [15:0] smpReg [4];
    logic [63:0] smpPad;
    logic [2:0] step;
    logic mixBusy;
    logic signed [18:0] acc;
    logic [15:0] pendVal;
    logic pendFlag;
    logic [1:0] chIdx;
    logic [4:0] volEff;
    logic signed [21:0] prod;
    logic signed [21:0] term;
    logic [15:0] satVal;
    logic mixDone;
    logic take;
    logic unusedAddr;

    serState_t state, stateNext;
    logic [15:0] divCnt, divNext;
    logic [5:0] bitCnt, bitNext;
    logic [32:0] shReg, shNext, shStep, loadWord;
    logic [15:0] ymFrame;
    logic sdNext, bckNext, loadNext, bitEnd;

    assign unusedAddr = ^iAddr[19:12];
    assign smpPad = 64'(iSamples);
    assign chIdx = (step < 3'(CHANNELS)) ? step[1:0] : 2'd0;
    assign volEff = clampVol(volReg[chIdx][VOL_MSB:0]);
    assign prod = smpReg[chIdx] * $signed({1'b0, volEff});
    assign term = volReg[chIdx][MUTE_BIT] ? '0 : prod >>> 4;
    assign satVal = (acc > 19'sd32767) ? 16'h7FFF : (acc < -19'sd32768) ? 16'h8000 : acc[15:0];
    assign mixDone = mixBusy && step == 3'(CHANNELS) && !iSampleEn;
    assign take = state == IDLE && pendFlag;

    always_ff @(posedge iClk)
        for (int n = 0; n < 4; n++)
            if (iRst) volReg[n] <= VOL_RESET;
            else if (iWr && n < CHANNELS && iAddr[11:0] == BASE + 12'(n)) volReg[n] <= iWrData;

    // A new strobe always wins, so a strobe during accumulation restarts the mix
    always_ff @(posedge iClk) begin
        if (iRst) begin
            mixBusy <= 1'b0;
            step <= '0;
            acc <= '0;
            pendVal <= '0;
            pendFlag <= 1'b0;
            oOverrun <= 1'b0;
            for (int n = 0; n < 4; n++) smpReg[n] <= '0;
        end else begin
            oOverrun <= mixDone && pendFlag && !take;
            pendFlag <= mixDone ? 1'b1 : take ? 1'b0 : pendFlag;
            if (iSampleEn) begin
                mixBusy <= 1'b1;
                step <= '0;
                acc <= '0;
                for (int n = 0; n < 4; n++) smpReg[n] <= smpPad[16*n +: 16];
            end else if (mixBusy) begin
                if (step == 3'(CHANNELS)) begin
                    mixBusy <= 1'b0;
                    pendVal <= satVal;
                end else begin
                    acc <= acc + term[18:0];
                    step <= step + 3'd1;
                end
            end
        end
    end

    generate
        if (MODE == MODE_YM) begin : gYm
            snd_ym_float uEnc (.sample(pendVal), .frame(ymFrame));
        end else begin : gNoYm
            assign ymFrame = '0;
        end
    endgenerate

    // I2S: leading zero slot gives the one-slot delay, then left and right copies MSB first
    assign loadWord = (MODE == MODE_I2S) ? {1'b0, pendVal, pendVal} : {17'b0, ymFrame};
    assign shStep = (MODE == MODE_I2S) ? shReg << 1 : shReg >> 1;
    assign bitEnd = divCnt == 16'(DIV - 1);

    always_comb begin
        stateNext = state;
        divNext = divCnt;
        bitNext = bitCnt;
        shNext = shReg;
        sdNext = oSd;
        bckNext = oBck;
        loadNext = oLoad;
        if (state == IDLE) begin
            sdNext = 1'b0;
            bckNext = 1'b0;
            loadNext = 1'b0;
            if (pendFlag) begin
                stateNext = SHIFT;
                divNext = '0;
                bitNext = '0;
                shNext = loadWord;
                sdNext = (MODE == MODE_I2S) ? loadWord[32] : loadWord[0];
            end
        end else begin
            divNext = bitEnd ? '0 : divCnt + 16'd1;
            if (bitEnd && !oBck) begin
                bckNext = 1'b1;
            end else if (bitEnd) begin
                bckNext = 1'b0;
                if (bitCnt == LAST_SLOT) begin
                    stateNext = IDLE;
                    sdNext = 1'b0;
                    loadNext = 1'b0;
                end else begin
                    bitNext = bitCnt + 6'd1;
                    shNext = shStep;
                    sdNext = (MODE == MODE_I2S) ? shStep[32] : shStep[0];
                    loadNext = (MODE == MODE_I2S) ? (bitNext >= 6'(I2S_SLOTS / 2) && bitNext < 6'(I2S_SLOTS))
                                                  : bitNext == 6'(YM_FRAME);
                    if (MODE == MODE_YM && bitNext == 6'(YM_FRAME)) begin
                        stateNext = LOAD;
                        sdNext = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            divCnt <= '0;
            bitCnt <= '0;
            shReg <= '0;
            oSd <= 1'b0;
            oBck <= 1'b0;
            oLoad <= 1'b0;
        end else begin
            state <= stateNext;
            divCnt <= divNext;
            bitCnt <= bitNext;
            shReg <= shNext;
            oSd <= sdNext;
            oBck <= bckNext;
            oLoad <= loadNext;
        end
    end
endmodule
